seg_letter_decoder: RTL and testbench
=====================================

# seg_letter_decoder

Receive-side counterpart of the letter-to-seven-segment display path. Samples a 7-bit active-low segment bus and waits for each pattern to hold steady. Converts every new stable glyph back into the team's 5-bit letter code and delivers it over a valid/ready handshake. Used to read back driven display glyphs (self-check, display-bus snooping, glyph-keyed input) inside the single-clock display subsystem.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted; legal range 2..255.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- seg_in  in  7  segment pattern, active-low (0 = segment lit), same bit mapping as the display driver; already synchronous to clk.
- letter_ready  in  1  downstream accepts letter_code this cycle.
- letter_valid  out  1  letter_code/letter_err hold a pending glyph.
- letter_code  out  5  letter code: bit-reversed letter index, index 1..26 = a..z, so letter_code[4] is index bit 0 (a=10000, b=01000, z=01011); 00000 = unknown.
- letter_err  out  1  pending glyph was not in the glyph table.
- overflow  out  1  sticky: an accepted glyph was dropped because output was still pending.

## Operation
- Glyph table, pattern as seg_in[6:0]:
  - a 0001000, b 0000011, c 1000110, d 0100001, e 0000110, f 0001110, g 1000010
  - h 0001011, i 1001111, j 1100001, k 0001010, l 1000111, m 1101010, n 1001000
  - o 1000000, p 0001100, q 0011000, r 1001100, s 0010010, t 0000111, u 1100011
  - v 1000001, w 1010101, x 0001001, y 0010001, z 0100100
  - blank 1111111.
- Stability tracker:
  - Registers cand (7b) and cnt, saturating at STABLE_CYCLES.
  - seg_in != cand: cand <= seg_in, cnt <= 1.
  - Otherwise: cnt increments until saturated.
- Stable event: seg_in == cand and cnt == STABLE_CYCLES-1 at an edge.
- Register last (7b) holds the most recently accepted pattern. A stable event is accepted only if cand != last; last <= cand on every accepted event.
- Accepted blank: updates last only, produces no output. A repeated letter therefore needs an intervening blank or other glyph.
- Accepted non-blank, table hit: output load with the table code, err=0.
- Accepted non-blank, table miss: output load with code 00000, err=1.
- Output register states:
  - EMPTY: letter_valid=0.
  - FULL: letter_valid=1.
- Output register transitions:
  - EMPTY, load: -> FULL.
  - FULL, letter_ready=1: transfer; -> EMPTY, or stays FULL with the new data if a load occurs the same cycle.
  - FULL, letter_ready=0, load: load is dropped, overflow <= 1, last is still updated, output unchanged.
- letter_code/letter_err stay constant while letter_valid=1 and letter_ready=0.
- overflow is cleared only by reset.

## Timing
- Reset values:
  - letter_valid=0, letter_code=00000, letter_err=0, overflow=0.
  - cand=1111111, cnt=STABLE_CYCLES, last=1111111.
  - A blank bus after reset therefore emits nothing.
- Latency: a new pattern first sampled at edge E1 and held through edge E(STABLE_CYCLES) gives letter_valid=1 immediately after edge E(STABLE_CYCLES).
- Any change before edge E(STABLE_CYCLES) restarts the count. A glitch shorter than STABLE_CYCLES cycles is ignored, and the previous pattern must then re-qualify for its full STABLE_CYCLES.
- Handshake: transfer on a rising edge where letter_valid && letter_ready. letter_ready is ignored while letter_valid=0. No combinational path from letter_ready to any output.
- Simultaneous transfer and load: new glyph is presented the next cycle with no bubble, and overflow is not set.
- Reset asserted mid-qualification or with output pending: the pending glyph is lost, and the state equals the reset values after that edge.
- Throughput: at most one glyph per STABLE_CYCLES cycles; at most one glyph per 2*STABLE_CYCLES cycles for back-to-back repeats via blank.

## Test plan
- Reset, seg_in=1111111 for 20 cycles, letter_ready=1 -> letter_valid stays 0, overflow=0.
- seg_in=0001000 held 4 cycles, STABLE_CYCLES=4, letter_ready=1 -> letter_valid pulses 1 cycle with letter_code=10000, letter_err=0; holding the pattern longer emits nothing more.
- Sequence a, blank, a (each 6 cycles) -> two transfers of 10000; sequence a then a with no blank -> one transfer.
- seg_in=0100100 held 3 cycles, then 1 cycle of 0000000, then 0100100 for 4 cycles -> single output 01011 (z), emitted only after the final 4-cycle hold; the 1-cycle 0000000 glitch is not emitted.
- seg_in=0000000 held 4 cycles -> letter_code=00000, letter_err=1.
- letter_ready=0, emit b (01000) then c (11000) -> output holds 01000, overflow=1; raise letter_ready -> 01000 transfers, c is not delivered; assert reset -> overflow=0, letter_valid=0.

Source files
------------

// File: rtl/seg_letter_decoder.sv
// seg_letter_decoder: reads a 7-bit active-low segment bus back into letter codes.
// A pattern must hold for STABLE_CYCLES samples before it counts. Each new stable
// glyph, other than a repeat or a blank, is decoded and offered on a
// single-entry valid/ready output register. If that register is still full, the
// glyph is dropped and the sticky overflow flag is set.
module seg_letter_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       letter_ready,
  output logic       letter_valid,
  output logic [4:0] letter_code,
  output logic       letter_err,
  output logic       overflow
);

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [7:0] SAT   = 8'(STABLE_CYCLES);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_e;

  // Map a glyph to its letter index (1..26). Unknown patterns map to 0.
  function automatic logic [4:0] glyph_index(input logic [6:0] p);
    logic [4:0] idx;
    case (p)
      7'b0001000: idx = 5'd1;   // a
      7'b0000011: idx = 5'd2;   // b
      7'b1000110: idx = 5'd3;   // c
      7'b0100001: idx = 5'd4;   // d
      7'b0000110: idx = 5'd5;   // e
      7'b0001110: idx = 5'd6;   // f
      7'b1000010: idx = 5'd7;   // g
      7'b0001011: idx = 5'd8;   // h
      7'b1001111: idx = 5'd9;   // i
      7'b1100001: idx = 5'd10;  // j
      7'b0001010: idx = 5'd11;  // k
      7'b1000111: idx = 5'd12;  // l
      7'b1101010: idx = 5'd13;  // m
      7'b1001000: idx = 5'd14;  // n
      7'b1000000: idx = 5'd15;  // o
      7'b0001100: idx = 5'd16;  // p
      7'b0011000: idx = 5'd17;  // q
      7'b1001100: idx = 5'd18;  // r
      7'b0010010: idx = 5'd19;  // s
      7'b0000111: idx = 5'd20;  // t
      7'b1100011: idx = 5'd21;  // u
      7'b1000001: idx = 5'd22;  // v
      7'b1010101: idx = 5'd23;  // w
      7'b0001001: idx = 5'd24;  // x
      7'b0010001: idx = 5'd25;  // y
      7'b0100100: idx = 5'd26;  // z
      default:    idx = 5'd0;
    endcase
    return idx;
  endfunction

  // The letter code carries the index bit-reversed, so code[4] is index bit 0.
  function automatic logic [4:0] bit_reverse5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  logic [6:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] last_q, last_d;
  logic       stable_evt, accept, load;
  logic [4:0] new_idx;

  out_state_e state_q, state_d;
  logic [4:0] code_q, code_d;
  logic       err_q, err_d;
  logic       ovf_q, ovf_d;
  logic       data_en;

  // Stability tracker and accept filter: find stable, non-repeated patterns.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (seg_in != cand_q) begin
      cand_d = seg_in;
      cnt_d  = 8'd1;
    end else if (cnt_q != SAT) begin
      cnt_d = cnt_q + 8'd1;
    end
    stable_evt = (seg_in == cand_q) && (cnt_q == SAT - 8'd1);
    accept     = stable_evt && (cand_q != last_q);
    last_d     = accept ? cand_q : last_q;
    load       = accept && (cand_q != BLANK);
    new_idx    = glyph_index(cand_q);
  end

  // Tracker state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= BLANK;
      cnt_q  <= SAT;
      last_q <= BLANK;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  // Output register next state. A load is taken when the register is empty or
  // drains this cycle. Otherwise the load is dropped and recorded as overflow.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (letter_ready && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    data_en = load && ((state_q == EMPTY) || letter_ready);
    code_d  = data_en ? bit_reverse5(new_idx) : code_q;
    err_d   = data_en ? (new_idx == 5'd0) : err_q;
    ovf_d   = ovf_q | (load && (state_q == FULL) && !letter_ready);
  end

  // Output register state and payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      code_q  <= 5'd0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come from registers only, so no combinational path from letter_ready.
  always_comb begin
    letter_valid = (state_q == FULL);
    letter_code  = code_q;
    letter_err   = err_q;
    overflow     = ovf_q;
  end

endmodule

// File: tb/tb_seg_letter_decoder.sv
// Directed bench for seg_letter_decoder with STABLE_CYCLES=4.
module tb_seg_letter_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic       letter_ready;
  logic       letter_valid;
  logic [4:0] letter_code;
  logic       letter_err;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  // Transfers observed on the handshake, taken on the falling edge before the
  // rising edge that performs them.
  int         xfer_n = 0;
  logic [4:0] xfer_code = 5'd0;
  logic       xfer_err = 1'b0;
  int         n0;

  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_A     = 7'b0001000;
  localparam logic [6:0] G_B     = 7'b0000011;
  localparam logic [6:0] G_C     = 7'b1000110;
  localparam logic [6:0] G_D     = 7'b0100001;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_F     = 7'b0001110;
  localparam logic [6:0] G_O     = 7'b1000000;
  localparam logic [6:0] G_Z     = 7'b0100100;
  localparam logic [6:0] G_BAD   = 7'b0000000;

  seg_letter_decoder #(.STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .seg_in       (seg_in),
    .letter_ready (letter_ready),
    .letter_valid (letter_valid),
    .letter_code  (letter_code),
    .letter_err   (letter_err),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && letter_valid && letter_ready) begin
      xfer_n    <= xfer_n + 1;
      xfer_code <= letter_code;
      xfer_err  <= letter_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving the bench 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    step(n);
  endtask

  initial begin
    reset = 1'b1;
    seg_in = G_BLANK;
    letter_ready = 1'b1;
    step(2);
    reset = 1'b0;
    check("rst_valid", 32'(letter_valid), 32'd0);
    check("rst_code", 32'(letter_code), 32'd0);
    check("rst_err", 32'(letter_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // A blank bus after reset produces nothing.
    n0 = xfer_n;
    hold(G_BLANK, 20);
    check("blank_xfers", 32'(xfer_n - n0), 32'd0);
    check("blank_valid", 32'(letter_valid), 32'd0);
    check("blank_ovf", 32'(overflow), 32'd0);

    // 'a' held exactly 4 edges is valid right after the 4th edge.
    n0 = xfer_n;
    hold(G_A, 3);
    check("a_not_yet", 32'(letter_valid), 32'd0);
    hold(G_A, 1);
    check("a_valid", 32'(letter_valid), 32'd1);
    check("a_code", 32'(letter_code), 32'b10000);
    check("a_err", 32'(letter_err), 32'd0);
    hold(G_A, 1);
    check("a_pulse_end", 32'(letter_valid), 32'd0);
    hold(G_A, 8);
    check("a_xfers", 32'(xfer_n - n0), 32'd1);
    check("a_xfer_code", 32'(xfer_code), 32'b10000);

    // A blank between repeats allows a second 'a'.
    n0 = xfer_n;
    hold(G_BLANK, 6);
    hold(G_A, 6);
    hold(G_BLANK, 6);
    hold(G_A, 6);
    check("a_blank_a_xfers", 32'(xfer_n - n0), 32'd2);
    check("a_blank_a_code", 32'(xfer_code), 32'b10000);

    // 'a' again without a blank, with a short 'o' glitch, gives no output.
    n0 = xfer_n;
    hold(G_O, 2);
    hold(G_A, 8);
    check("a_a_xfers", 32'(xfer_n - n0), 32'd0);

    // 'z' held 3 edges, a 1-edge glitch, then 4 edges gives a single 'z'.
    n0 = xfer_n;
    hold(G_Z, 3);
    hold(G_BAD, 1);
    hold(G_Z, 3);
    check("z_requalify", 32'(letter_valid), 32'd0);
    hold(G_Z, 1);
    check("z_valid", 32'(letter_valid), 32'd1);
    check("z_code", 32'(letter_code), 32'b01011);
    hold(G_Z, 4);
    check("z_xfers", 32'(xfer_n - n0), 32'd1);
    check("z_xfer_code", 32'(xfer_code), 32'b01011);

    // An unknown glyph gives code 0 and sets the error flag.
    hold(G_BAD, 4);
    check("bad_valid", 32'(letter_valid), 32'd1);
    check("bad_code", 32'(letter_code), 32'd0);
    check("bad_err", 32'(letter_err), 32'd1);
    hold(G_BAD, 2);

    // Overflow case: 'b' pending, 'c' dropped.
    letter_ready = 1'b0;
    hold(G_BLANK, 6);
    hold(G_B, 4);
    check("b_valid", 32'(letter_valid), 32'd1);
    check("b_code", 32'(letter_code), 32'b01000);
    check("b_err", 32'(letter_err), 32'd0);
    hold(G_C, 6);
    check("c_hold_code", 32'(letter_code), 32'b01000);
    check("c_hold_valid", 32'(letter_valid), 32'd1);
    check("c_ovf", 32'(overflow), 32'd1);
    n0 = xfer_n;
    letter_ready = 1'b1;
    hold(G_C, 1);
    check("b_drained", 32'(letter_valid), 32'd0);
    hold(G_C, 6);
    check("b_xfers", 32'(xfer_n - n0), 32'd1);
    check("b_xfer_code", 32'(xfer_code), 32'b01000);
    check("ovf_sticky", 32'(overflow), 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst2_ovf", 32'(overflow), 32'd0);
    check("rst2_valid", 32'(letter_valid), 32'd0);

    // Transfer and load on the same edge: no bubble and no overflow.
    letter_ready = 1'b0;
    hold(G_BLANK, 6);
    hold(G_D, 4);
    check("d_code", 32'(letter_code), 32'b00100);
    n0 = xfer_n;
    hold(G_E, 3);
    letter_ready = 1'b1;
    hold(G_E, 1);
    check("e_nobubble_valid", 32'(letter_valid), 32'd1);
    check("e_code", 32'(letter_code), 32'b10100);
    check("e_no_ovf", 32'(overflow), 32'd0);
    hold(G_E, 3);
    check("de_xfers", 32'(xfer_n - n0), 32'd2);
    check("de_last_code", 32'(xfer_code), 32'b10100);

    // Reset while a glyph is pending discards it.
    letter_ready = 1'b0;
    hold(G_BLANK, 6);
    hold(G_F, 4);
    check("f_pending", 32'(letter_valid), 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst3_valid", 32'(letter_valid), 32'd0);
    check("rst3_code", 32'(letter_code), 32'd0);
    seg_in = G_BLANK;
    step(6);
    check("rst3_idle", 32'(letter_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
